// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// operation codes, FSM state encoding and divider defaults.
package md_pkg;

    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports: start/cancel control, dividend/divisor in, done + quotient/remainder out.
module div_radix2
    import md_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [5:0] LAST = 6'(DIV_CYCLES - 1);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        take;
    logic        last;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    // Bring down the next dividend bit and try to subtract the divisor.
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dvs_q};
        take     = (shifted >= {1'b0, dvs_q});
        rem_step = take ? 32'(diff) : 32'(shifted);
        quo_step = {quo_q[30:0], take};
        last     = run_q && (cnt_q == LAST);
    end

    // Results are the values being formed by the final iteration, so the
    // caller can capture them on the same edge that ends it.
    assign done      = last;
    assign quotient  = quo_step;
    assign remainder = rem_step;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cancel) begin
                run_d = 1'b0;
            end else begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (last) begin
                    run_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO register file with multi-cycle MULT/DIV sequencing and pipeline stall.
// Ports: E-stage op/operands/cancel in; hi_o/lo_o, stall_req, busy, done out.
module hilo_md_ctrl
    import md_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        validE,
    input  logic [2:0]  mdopE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancel,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_req,
    output logic        busy,
    output logic        done
);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;

    md_op_e      op;
    logic        accept;
    logic        md_req;
    logic        sgn_in;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign op     = md_op_e'(mdopE);
    assign accept = validE & ~cancel;
    assign md_req = (op == MD_MULT) | (op == MD_MULTU) |
                    (op == MD_DIV)  | (op == MD_DIVU);
    assign sgn_in = (op == MD_MULT) | (op == MD_DIV);

    // Divider works on magnitudes; 0x80000000 maps onto itself, which is
    // exactly the unsigned magnitude we need.
    assign mag_a = (sgn_in & srcaE[31]) ? (~srcaE + 32'd1) : srcaE;
    assign mag_b = (sgn_in & srcbE[31]) ? (~srcbE + 32'd1) : srcbE;

    // Low 64 bits of a product of 64-bit extended operands equal the
    // signed or unsigned 32x32 product.
    always_comb begin
        ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        quo_fix = div_quo;
        rem_fix = div_rem;
        if (sgn_q & (a_q[31] ^ b_q[31])) begin
            quo_fix = ~div_quo + 32'd1;
        end
        if (sgn_q & a_q[31]) begin
            rem_fix = ~div_rem + 32'd1;
        end
    end

    div_radix2 #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .cancel   (cancel),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        div_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            a_d     = srcaE;
                            b_d     = srcbE;
                            sgn_d   = sgn_in;
                            state_d = ST_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            a_d       = srcaE;
                            b_d       = srcbE;
                            sgn_d     = sgn_in;
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                        end
                        MD_MTHI: hi_d = srcaE;
                        MD_MTLO: lo_d = srcaE;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (div_done) begin
                    // Zero divisor: all-ones quotient, dividend as remainder.
                    if (b_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
        end
    end

    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign busy      = (state_q == ST_MUL) | (state_q == ST_DIV);
    assign done      = (state_q == ST_DONE);
    assign stall_req = rst & (busy |
                       ((state_q == ST_IDLE) & accept & md_req));

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Randomized bench for hilo_md_ctrl against a transaction-level model,
// plus directed cases with literal HI/LO and stall-count expectations.
module tb_hilo_md_ctrl;

    localparam int NDIV = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        validE = 1'b0;
    logic [2:0]  mdopE = 3'd0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        cancel = 1'b0;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_req;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    hilo_md_ctrl #(.DIV_CYCLES(NDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .validE   (validE),
        .mdopE    (mdopE),
        .srcaE    (srcaE),
        .srcbE    (srcbE),
        .cancel   (cancel),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .stall_req(stall_req),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Architectural result of one HI/LO operation, {hi, lo}.
    function automatic logic [63:0] md_result(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sp, sa, sb, q, r;
        longint unsigned up;
        logic [63:0]     res;
        res = '0;
        case (op)
            3'd1: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                res = sp;
            end
            3'd2: begin
                up  = {32'd0, a} * {32'd0, b};
                res = up;
            end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd4) begin
                    res = {a % b, a / b};
                end else begin
                    sa  = longint'($signed(a));
                    sb  = longint'($signed(b));
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Model: remaining busy cycles, a pending result, and a done flag.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_rem = 0;
    bit          m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            if (cancel) begin
                m_rem <= 0;
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end
        end else if (validE && !cancel) begin
            case (mdopE)
                3'd1, 3'd2: begin
                    m_rem <= 1;
                    m_res <= md_result(mdopE, srcaE, srcbE);
                end
                3'd3, 3'd4: begin
                    m_rem <= NDIV;
                    m_res <= md_result(mdopE, srcaE, srcbE);
                end
                3'd5: m_hi <= srcaE;
                3'd6: m_lo <= srcaE;
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic e_stall, e_busy, e_done;
        e_busy  = (m_rem > 0);
        e_done  = m_done;
        e_stall = rst && (e_busy || (!m_done && validE && !cancel &&
                  mdopE >= 3'd1 && mdopE <= 3'd4));
        checks++;
        if (hi_o !== m_hi || lo_o !== m_lo || stall_req !== e_stall ||
            busy !== e_busy || done !== e_done) begin
            errors++;
            $display("FAIL cycle t=%0t hi=%h/%h lo=%h/%h st=%b/%b bz=%b/%b dn=%b/%b (got/exp)",
                     $time, hi_o, m_hi, lo_o, m_lo, stall_req, e_stall,
                     busy, e_busy, done, e_done);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one instruction in E and hold it until the pipeline moves on.
    task automatic issue(input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at,
                         output int stalls, output int dones);
        bit st;
        bit fin;
        validE = v;
        mdopE  = op;
        srcaE  = a;
        srcbE  = b;
        cancel = 1'b0;
        stalls = 0;
        dones  = 0;
        fin    = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            if (i == cancel_at) cancel = 1'b1;
            @(negedge clk);
            st = stall_req;
            if (st) stalls++;
            if (done) dones++;
            @(posedge clk);
            #2;
            if (!st || cancel) fin = 1'b1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: op %0d still stalled after 100 cycles", op);
        end
        validE = 1'b0;
        mdopE  = 3'd0;
        cancel = 1'b0;
        srcaE  = $urandom;
        srcbE  = $urandom;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int s, d, cat;
        logic v;
        logic [2:0] op;

        #1 rst = 1'b0;
        validE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mdopE  = 3'($urandom_range(1, 6));
            srcaE  = $urandom;
            srcbE  = $urandom;
            cancel = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #2;
        validE = 1'b0;
        cancel = 1'b0;
        mdopE  = 3'd0;
        rst    = 1'b1;

        issue(1, 3'd1, 32'hFFFF_FFFF, 32'd2, -1, s, d);
        chk("mult_stalls", 64'(s), 64'd2);
        chk("mult_dones", 64'(d), 64'd1);
        @(negedge clk);
        chk("mult_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
        settle();

        issue(1, 3'd2, 32'hFFFF_FFFF, 32'd2, -1, s, d);
        @(negedge clk);
        chk("multu_res", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
        settle();

        issue(1, 3'd4, 32'd100, 32'd7, -1, s, d);
        chk("divu_stalls", 64'(s), 64'd33);
        chk("divu_dones", 64'(d), 64'd1);
        @(negedge clk);
        chk("divu_res", {hi_o, lo_o}, {32'd2, 32'd14});
        settle();

        issue(1, 3'd3, 32'hFFFF_FFF9, 32'd2, -1, s, d);
        @(negedge clk);
        chk("div_neg", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        settle();

        issue(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, s, d);
        @(negedge clk);
        chk("div_ovf", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        settle();

        issue(1, 3'd4, 32'd5, 32'd0, -1, s, d);
        chk("div0_stalls", 64'(s), 64'd33);
        @(negedge clk);
        chk("div0_res", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);
        settle();

        // Cancel during iteration 10 (loop index 0 is the IDLE cycle).
        issue(1, 3'd3, 32'd1000, 32'd3, 11, s, d);
        chk("cancel_stalls", 64'(s), 64'd12);
        chk("cancel_dones", 64'(d), 64'd0);
        @(negedge clk);
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_done", 64'(done), 64'd0);
        chk("cancel_hilo", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);
        settle();

        issue(1, 3'd5, 32'h0000_1234, 32'd0, -1, s, d);
        chk("mthi_stalls", 64'(s), 64'd0);
        @(negedge clk);
        chk("mthi_hi", 64'(hi_o), 64'h1234);
        settle();

        // MULT then DIV presented right after DONE.
        issue(1, 3'd1, 32'd3, 32'd4, -1, s, d);
        chk("b2b_mult_dones", 64'(d), 64'd1);
        issue(1, 3'd3, 32'd100, 32'hFFFF_FFFD, -1, s, d);
        chk("b2b_div_stalls", 64'(s), 64'd33);
        chk("b2b_div_dones", 64'(d), 64'd1);
        @(negedge clk);
        chk("b2b_div_res", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFDF);
        settle();

        // Reset in the middle of a divide, then MULT on the first edge.
        validE = 1'b1;
        mdopE  = 3'd3;
        srcaE  = 32'd77;
        srcbE  = 32'd5;
        repeat (6) settle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stall", 64'(stall_req), 64'd0);
        chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
        settle();
        rst = 1'b1;
        issue(1, 3'd1, 32'd6, 32'd7, -1, s, d);
        chk("postrst_stalls", 64'(s), 64'd2);
        @(negedge clk);
        chk("postrst_res", {hi_o, lo_o}, 64'd42);
        settle();

        for (int n = 0; n < 300; n++) begin
            v   = ($urandom_range(0, 7) != 0);
            op  = 3'($urandom_range(0, 6));
            cat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            issue(v, op, pick(), pick(), cat, s, d);
        end

        repeat (2) settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
